// File: rtl/color_grid_pkg.sv
// Shared types and constants for the colour grid manager: FSM state codes,
// error codes, the header opcode and a width helper.
package color_grid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GET_DATA = 2'd1,
        ST_WRITE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OPCODE  = 2'd3
    } err_t;

    // Header byte bits [7:6]; only the write command is understood.
    localparam logic [1:0] OP_WRITE = 2'b00;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/color_grid_scan.sv
// Raster position tracker: detects HSync/VSync rising edges, runs the x/y
// pixel counters (saturating at the active area) and keeps column/row region
// counters in step using per-segment counters, so no divider is needed.
module color_grid_scan
    import color_grid_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int REGIONS_X = 2,
    parameter int REGIONS_Y = 2,
    parameter int COL_W     = 1,
    parameter int ROW_W     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             vsync_rise
);

    localparam int SEG_W = H_ACTIVE / REGIONS_X;
    localparam int SEG_H = V_ACTIVE / REGIONS_Y;
    localparam int XW    = clog2_min1(H_ACTIVE);
    localparam int YW    = clog2_min1(V_ACTIVE);
    localparam int SXW   = clog2_min1(SEG_W);
    localparam int SYW   = clog2_min1(SEG_H);

    localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [SXW-1:0] SX_LAST = SXW'(SEG_W - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(SEG_H - 1);

    logic           hsync_d, vsync_d;
    logic           hsync_rise;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [SXW-1:0] seg_x;
    logic [SYW-1:0] seg_y;

    assign hsync_rise = hsync & ~hsync_d;
    assign vsync_rise = vsync & ~vsync_d;

    // Delayed sync copies for rising-edge detection.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values;
        // a blocking = here would let later statements see this cycle's update.
        if (rst) begin
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            hsync_d <= hsync;
            vsync_d <= vsync;
        end
    end

    // Horizontal position: clear on line start, otherwise advance until the last pixel.
    always_ff @(posedge clk) begin
        if (rst || hsync_rise) begin
            x     <= '0;
            seg_x <= '0;
            col   <= '0;
        end else if (x != X_LAST) begin
            x <= x + 1'b1;
            if (seg_x == SX_LAST) begin
                seg_x <= '0;
                col   <= col + 1'b1;
            end else begin
                seg_x <= seg_x + 1'b1;
            end
        end
    end

    // Vertical position: clear on frame start, advance one line per HSync edge.
    always_ff @(posedge clk) begin
        if (rst || vsync_rise) begin
            y     <= '0;
            seg_y <= '0;
            row   <= '0;
        end else if (hsync_rise && (y != Y_LAST)) begin
            y <= y + 1'b1;
            if (seg_y == SY_LAST) begin
                seg_y <= '0;
                row   <= row + 1'b1;
            end else begin
                seg_y <= seg_y + 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_grid_manager.sv
// Colour grid manager: takes two-byte UART commands (header = region index,
// then colour) into a per-region colour table through a C_Valid/C_Rdy config
// port, and paints the VGA raster from that table by screen region.
// Optional feature macro: COLOR_GRID_DEBUG_EN -- when defined, VGA_Debugg=1
// replaces the pixel colour with the zero-extended region index.
module color_grid_manager
    import color_grid_pkg::*;
#(
    parameter int REGIONS_X   = 2,
    parameter int REGIONS_Y   = 2,
    parameter int COLOR_WIDTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int TIMEOUT     = 1024,
    localparam int N_REGIONS  = REGIONS_X * REGIONS_Y,
    localparam int ADDR_W     = clog2_min1(N_REGIONS)
) (
    input  logic                   Clk,
    input  logic                   rst,
    input  logic                   Empty,
    input  logic [7:0]             RXD_Data,
    output logic                   Rd,
    output logic [ADDR_W-1:0]      C_Addr,
    output logic [COLOR_WIDTH-1:0] C_Data,
    output logic                   C_Valid,
    input  logic                   C_Rdy,
    input  logic                   Vertical_Split,
    input  logic                   Horizontal_Split,
    input  logic                   VGA_Debugg,
    input  logic                   HSync,
    input  logic                   VSync,
    output logic [1:0]             Config_Status,
    output logic [5:0]             Config_Notification,
    output logic                   Config_Notification_Valid,
    output logic [1:0]             Config_Error,
    output logic                   Error_Valid,
    output logic [7:0]             VGA_Notification,
    output logic                   VGA_Notification_Valid,
    output logic [COLOR_WIDTH-1:0] Data_VGA
);

    localparam int COL_W = clog2_min1(REGIONS_X);
    localparam int ROW_W = clog2_min1(REGIONS_Y);
    localparam int TMR_W = clog2_min1(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t                 state, next_state;
    logic [5:0]             reg_idx;
    logic [COLOR_WIDTH-1:0] color_q;
    logic [TMR_W-1:0]       timer;
    logic [COLOR_WIDTH-1:0] color_table [N_REGIONS];

    logic                   rd_req, hdr_ok, data_take, wr_fire, err_fire;
    err_t                   err_code;
    logic [5:0]             hdr_idx;

    logic [COL_W-1:0]       col, col_eff;
    logic [ROW_W-1:0]       row, row_eff;
    logic [ADDR_W-1:0]      pix_idx;
    logic                   vsync_rise;

    assign hdr_idx       = RXD_Data[5:0];
    assign Rd            = rd_req & ~rst;
    assign C_Addr        = reg_idx[ADDR_W-1:0];
    assign C_Data        = color_q;
    assign Config_Status = state;

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state, byte pop, config handshake and error decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        next_state = state;
        rd_req     = 1'b0;
        C_Valid    = 1'b0;
        hdr_ok     = 1'b0;
        data_take  = 1'b0;
        wr_fire    = 1'b0;
        err_fire   = 1'b0;
        err_code   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (!Empty) begin
                    rd_req = 1'b1;
                    if (RXD_Data[7:6] != OP_WRITE) begin
                        err_fire = 1'b1;
                        err_code = ERR_OPCODE;
                    end else if (int'(hdr_idx) >= N_REGIONS) begin
                        err_fire = 1'b1;
                        err_code = ERR_RANGE;
                    end else begin
                        hdr_ok     = 1'b1;
                        next_state = ST_GET_DATA;
                    end
                end
            end
            ST_GET_DATA: begin
                if (!Empty) begin
                    rd_req     = 1'b1;
                    data_take  = 1'b1;
                    next_state = ST_WRITE;
                end else if (timer == TMR_LAST) begin
                    err_fire   = 1'b1;
                    err_code   = ERR_TIMEOUT;
                    next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                C_Valid = 1'b1;
                if (C_Rdy) begin
                    wr_fire    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Command registers, inter-byte timer and status pulses.
    always_ff @(posedge Clk) begin
        if (rst) begin
            reg_idx                   <= '0;
            color_q                   <= '0;
            timer                     <= '0;
            Config_Error              <= '0;
            Error_Valid               <= 1'b0;
            Config_Notification       <= '0;
            Config_Notification_Valid <= 1'b0;
        end else begin
            Error_Valid               <= err_fire;
            Config_Notification_Valid <= wr_fire;
            if (err_fire) Config_Error <= err_code;
            if (wr_fire)  Config_Notification <= reg_idx;
            if (hdr_ok) begin
                reg_idx <= hdr_idx;
                timer   <= '0;
            end else if (state == ST_GET_DATA) begin
                timer <= timer + 1'b1;
            end
            if (data_take) color_q <= COLOR_WIDTH'(RXD_Data);
        end
    end

    // Colour table, written on the config handshake cycle.
    always_ff @(posedge Clk) begin
        if (rst) begin
            // NOTE: the table is cleared by reset because a black screen after
            // reset is required behaviour; this keeps it out of RAM macros.
            for (int i = 0; i < N_REGIONS; i++) color_table[i] <= '0;
        end else if (wr_fire) begin
            color_table[reg_idx[ADDR_W-1:0]] <= color_q;
        end
    end

    color_grid_scan #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .REGIONS_X (REGIONS_X),
        .REGIONS_Y (REGIONS_Y),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_scan (
        .clk        (Clk),
        .rst        (rst),
        .hsync      (HSync),
        .vsync      (VSync),
        .col        (col),
        .row        (row),
        .vsync_rise (vsync_rise)
    );

    // Region index of the current pixel, with disabled splits collapsing to 0.
    always_comb begin
        col_eff = Vertical_Split   ? col : '0;
        row_eff = Horizontal_Split ? row : '0;
        pix_idx = ADDR_W'(int'(row_eff) * REGIONS_X + int'(col_eff));
    end

    // Registered pixel colour; a same-cycle table write shows up one cycle later.
    always_ff @(posedge Clk) begin
        if (rst) begin
            Data_VGA <= '0;
        end else begin
`ifdef COLOR_GRID_DEBUG_EN
            if (VGA_Debugg) Data_VGA <= COLOR_WIDTH'(pix_idx);
            else            Data_VGA <= color_table[pix_idx];
`else
            Data_VGA <= color_table[pix_idx];
`endif
        end
    end

`ifndef COLOR_GRID_DEBUG_EN
    logic unused_debug;
    assign unused_debug = VGA_Debugg;
`endif

    // Frame counter, bumped on every VSync rising edge.
    always_ff @(posedge Clk) begin
        if (rst) begin
            VGA_Notification       <= '0;
            VGA_Notification_Valid <= 1'b0;
        end else begin
            VGA_Notification_Valid <= vsync_rise;
            if (vsync_rise) VGA_Notification <= VGA_Notification + 1'b1;
        end
    end

endmodule

// File: tb/tb_color_grid_manager.sv
// Directed self-checking bench for color_grid_manager at default parameters
// (2x2 regions, 640x480, 8-bit colour, 1024-cycle timeout).
module tb_color_grid_manager;

    logic       Clk, rst, Empty, C_Rdy;
    logic [7:0] RXD_Data;
    logic       Rd, C_Valid;
    logic [1:0] C_Addr;
    logic [7:0] C_Data;
    logic       Vertical_Split, Horizontal_Split, VGA_Debugg, HSync, VSync;
    logic [1:0] Config_Status, Config_Error;
    logic [5:0] Config_Notification;
    logic       Config_Notification_Valid, Error_Valid, VGA_Notification_Valid;
    logic [7:0] VGA_Notification, Data_VGA;

    int n_checks = 0;
    int n_fail   = 0;

    color_grid_manager dut (
        .Clk                       (Clk),
        .rst                       (rst),
        .Empty                     (Empty),
        .RXD_Data                  (RXD_Data),
        .Rd                        (Rd),
        .C_Addr                    (C_Addr),
        .C_Data                    (C_Data),
        .C_Valid                   (C_Valid),
        .C_Rdy                     (C_Rdy),
        .Vertical_Split            (Vertical_Split),
        .Horizontal_Split          (Horizontal_Split),
        .VGA_Debugg                (VGA_Debugg),
        .HSync                     (HSync),
        .VSync                     (VSync),
        .Config_Status             (Config_Status),
        .Config_Notification       (Config_Notification),
        .Config_Notification_Valid (Config_Notification_Valid),
        .Config_Error              (Config_Error),
        .Error_Valid               (Error_Valid),
        .VGA_Notification          (VGA_Notification),
        .VGA_Notification_Valid    (VGA_Notification_Valid),
        .Data_VGA                  (Data_VGA)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one clock; returns just after that edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        Empty    = 1'b0;
        RXD_Data = b;
        @(posedge Clk);
        #1 Empty = 1'b1;
    endtask

    // Full write with C_Rdy already high; returns just after the handshake edge.
    task automatic write_region(input logic [5:0] idx, input logic [7:0] col);
        send_byte({2'b00, idx});
        send_byte(col);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; Empty = 1'b1; RXD_Data = 8'h00; C_Rdy = 1'b0;
        Vertical_Split = 1'b1; Horizontal_Split = 1'b1; VGA_Debugg = 1'b0;
        HSync = 1'b0; VSync = 1'b0;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_status",  Config_Status, 2'd0);
        check("rst_cvalid",  C_Valid, 1'b0);
        check("rst_data",    Data_VGA, 8'h00);
        check("rst_err",     Config_Error, 2'd0);
        check("rst_vganote", VGA_Notification, 8'h00);
        rst = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("idle_rd_empty", Rd, 1'b0);

        // Basic write 0x03, 0x5A with C_Rdy high
        C_Rdy = 1'b1;
        @(negedge Clk);
        Empty = 1'b0; RXD_Data = 8'h03;
        #1 check("hdr_rd", Rd, 1'b1);
        @(posedge Clk);
        #1 Empty = 1'b1;
        @(negedge Clk);
        check("getdata_status", Config_Status, 2'd1);
        check("getdata_rd_empty", Rd, 1'b0);
        send_byte(8'h5A);
        @(negedge Clk);
        check("wr_cvalid", C_Valid, 1'b1);
        check("wr_caddr",  C_Addr, 2'd3);
        check("wr_cdata",  C_Data, 8'h5A);
        check("wr_status", Config_Status, 2'd2);
        check("wr_rd_blocked", Rd, 1'b0);
        @(posedge Clk); @(negedge Clk);
        check("note_valid",     Config_Notification_Valid, 1'b1);
        check("note_idx",       Config_Notification, 6'd3);
        check("post_hs_cvalid", C_Valid, 1'b0);
        check("post_hs_status", Config_Status, 2'd0);
        @(negedge Clk);
        check("note_pulse_end", Config_Notification_Valid, 1'b0);

        // Back-pressure: C_Rdy low for 10 cycles
        C_Rdy = 1'b0;
        send_byte(8'h01);
        send_byte(8'h22);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("bp_cvalid", C_Valid, 1'b1);
            check("bp_caddr",  C_Addr, 2'd1);
            check("bp_cdata",  C_Data, 8'h22);
            check("bp_status", Config_Status, 2'd2);
        end
        C_Rdy = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("bp_note_valid", Config_Notification_Valid, 1'b1);
        check("bp_note_idx",   Config_Notification, 6'd1);
        check("bp_done_cvalid", C_Valid, 1'b0);

        // Region out of range
        send_byte(8'h04);
        @(negedge Clk);
        check("range_err",    Config_Error, 2'd1);
        check("range_errv",   Error_Valid, 1'b1);
        check("range_status", Config_Status, 2'd0);
        check("range_cvalid", C_Valid, 1'b0);
        @(negedge Clk);
        check("range_errv_end", Error_Valid, 1'b0);

        // Bad opcode
        send_byte(8'hC1);
        @(negedge Clk);
        check("op_err",    Config_Error, 2'd3);
        check("op_errv",   Error_Valid, 1'b1);
        check("op_status", Config_Status, 2'd0);

        // Inter-byte timeout: still waiting after 1023 idle cycles, gone after 1024
        send_byte(8'h02);
        repeat (1023) @(posedge Clk);
        @(negedge Clk);
        check("to_still_wait", Config_Status, 2'd1);
        @(posedge Clk); @(negedge Clk);
        check("to_status", Config_Status, 2'd0);
        check("to_err",    Config_Error, 2'd2);
        check("to_errv",   Error_Valid, 1'b1);

        // Fill the table
        write_region(6'd0, 8'h11);
        write_region(6'd1, 8'h22);
        write_region(6'd2, 8'h33);
        write_region(6'd3, 8'h44);

        // Frame start
        @(negedge Clk); VSync = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("vga_note_valid", VGA_Notification_Valid, 1'b1);
        check("vga_note_cnt",   VGA_Notification, 8'd1);
        VSync = 1'b0;
        @(negedge Clk);
        check("vga_note_end", VGA_Notification_Valid, 1'b0);

        // 239 lines, then line 240 tracked pixel by pixel
        for (int i = 0; i < 239; i++) begin
            @(negedge Clk); HSync = 1'b1;
            @(negedge Clk); HSync = 1'b0;
        end
        @(negedge Clk); HSync = 1'b1;
        @(posedge Clk);
        @(negedge Clk); HSync = 1'b0;
        repeat (320) @(posedge Clk);
        @(negedge Clk);
        check("pix_x319_y240", Data_VGA, 8'h33);
        @(posedge Clk); @(negedge Clk);
        check("pix_x320_y240", Data_VGA, 8'h44);

        // Split enables
        Vertical_Split = 1'b0; Horizontal_Split = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("split_none", Data_VGA, 8'h11);
        Vertical_Split = 1'b1; Horizontal_Split = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("split_col_only", Data_VGA, 8'h22);
        Vertical_Split = 1'b0; Horizontal_Split = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("split_row_only", Data_VGA, 8'h33);
        Vertical_Split = 1'b1; Horizontal_Split = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("split_both", Data_VGA, 8'h44);

        // Write to the region being displayed: old value first, new one a cycle later
        send_byte(8'h03);
        send_byte(8'h55);
        @(negedge Clk);
        check("rw_before", Data_VGA, 8'h44);
        @(posedge Clk); @(negedge Clk);
        check("rw_same_cycle", Data_VGA, 8'h44);
        @(posedge Clk); @(negedge Clk);
        check("rw_next_cycle", Data_VGA, 8'h55);

        // Reset in the middle of a handshake
        C_Rdy = 1'b0;
        send_byte(8'h00);
        send_byte(8'h99);
        @(negedge Clk);
        check("mid_wr_cvalid", C_Valid, 1'b1);
        rst = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("mrst_cvalid",  C_Valid, 1'b0);
        check("mrst_status",  Config_Status, 2'd0);
        check("mrst_data",    Data_VGA, 8'h00);
        check("mrst_vganote", VGA_Notification, 8'h00);
        check("mrst_note",    Config_Notification, 6'd0);
        check("mrst_err",     Config_Error, 2'd0);
        rst = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("mrst_table0", Data_VGA, 8'h00);
        check("mrst_cvalid_after", C_Valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
